// File: rtl/parking_access_controller_if.sv
// Interface bundling the front-end session signals and the P/Q write-enable
// and status outputs of the parking access controller.
// master: keypad/token front end. slave: the controller.
interface parking_access_controller_if #(
    parameter int TOKEN_W = 3,
    parameter int TIME_W  = 8,
    parameter int FAIL_W  = 2
);
    logic               request;
    logic               confirm;
    logic [TOKEN_W-1:0] system_token;
    logic [TOKEN_W-1:0] user_token;
    logic [TIME_W-1:0]  time_data;
    logic               P_register_enable;
    logic               Q_register_enable;
    logic               busy;
    logic               locked;
    logic [FAIL_W-1:0]  fail_count;

    modport master (
        output request, confirm, system_token, user_token, time_data,
        input  P_register_enable, Q_register_enable, busy, locked, fail_count
    );

    modport slave (
        input  request, confirm, system_token, user_token, time_data,
        output P_register_enable, Q_register_enable, busy, locked, fail_count
    );
endinterface

// File: rtl/parking_access_controller.sv
// parking_access_controller
// Token-checked session sequencer that issues a single one-cycle write enable
// to the peak (P) or off-peak (Q) rate register after: request, confirm with
// matching token, second confirm. Includes an idle timeout per session.
// Optional feature macro: ACCESS_LOCKOUT_EN
//   defined     -> mismatching confirms are counted; reaching MAX_TRIES enters
//                  a sticky LOCKOUT state left only by reset.
//   not defined -> a mismatching confirm aborts the session to RELEASE;
//                  locked and fail_count are tied to zero.
// All outputs are registered and decoded from the next state, so the enable
// is high exactly in the cycle the FSM sits in ENABLE.
module parking_access_controller #(
    parameter int                TOKEN_W     = 3,
    parameter int                TIME_W      = 8,
    parameter logic [TIME_W-1:0] PEAK_THRESH = 8'hF0,
    parameter int                MAX_TRIES   = 3,
    parameter int                TIMEOUT     = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    parking_access_controller_if.slave    bus
);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READY    = 3'd1,
        ST_VERIFIED = 3'd2,
        ST_ENABLE   = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_next_s;
    logic               p_en_r;
    logic               q_en_r;
    logic               busy_r;
    logic               token_match_s;
    logic               timeout_s;
    logic               peak_s;

`ifdef ACCESS_LOCKOUT_EN
    logic [FAIL_W-1:0]  fail_count_r;
    logic [FAIL_W-1:0]  fail_next_s;
    logic [FAIL_W-1:0]  fail_inc_s;
    logic               locked_r;
`endif

    assign token_match_s = (bus.user_token == bus.system_token);
    assign timeout_s     = (timer_r == TIMER_W'(TIMEOUT));
    // Time is sampled in the cycle of the second confirm; the resulting
    // choice is captured in the enable registers at the same edge.
    assign peak_s        = (bus.time_data >= PEAK_THRESH);

`ifdef ACCESS_LOCKOUT_EN
    assign fail_inc_s = (fail_count_r == FAIL_W'(MAX_TRIES)) ?
                        fail_count_r : (fail_count_r + FAIL_W'(1));
`endif

    // Next-state, idle timer and failed-attempt counter decode.
    always_comb begin
        state_next_s = state_r;
`ifdef ACCESS_LOCKOUT_EN
        fail_next_s  = fail_count_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.request) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READY: begin
                if (!bus.request) begin
                    state_next_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_next_s = ST_RELEASE;
                end else if (bus.confirm) begin
                    if (token_match_s) begin
                        state_next_s = ST_VERIFIED;
`ifdef ACCESS_LOCKOUT_EN
                        fail_next_s  = '0;
`endif
                    end else begin
`ifdef ACCESS_LOCKOUT_EN
                        fail_next_s = fail_inc_s;
                        if (fail_inc_s == FAIL_W'(MAX_TRIES)) begin
                            state_next_s = ST_LOCKOUT;
                        end else begin
                            state_next_s = ST_READY;
                        end
`else
                        state_next_s = ST_RELEASE;
`endif
                    end
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_VERIFIED: begin
                if (!bus.request) begin
                    state_next_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_next_s = ST_RELEASE;
                end else if (bus.confirm) begin
                    state_next_s = ST_ENABLE;
                end else begin
                    state_next_s = ST_VERIFIED;
                end
            end
            ST_ENABLE: begin
                if (!bus.request) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.request) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RELEASE;
                end
            end
            ST_LOCKOUT: begin
                state_next_s = ST_LOCKOUT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Timer runs only while waiting in READY/VERIFIED; confirm or any
        // state change restarts it.
        if ((state_next_s == state_r) && !bus.confirm &&
            ((state_r == ST_READY) || (state_r == ST_VERIFIED))) begin
            if (timeout_s) begin
                timer_next_s = timer_r;
            end else begin
                timer_next_s = timer_r + TIMER_W'(1);
            end
        end else begin
            timer_next_s = '0;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            p_en_r       <= 1'b0;
            q_en_r       <= 1'b0;
            busy_r       <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            fail_count_r <= '0;
            locked_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_next_s;
            timer_r      <= timer_next_s;
            p_en_r       <= (state_next_s == ST_ENABLE) && peak_s;
            q_en_r       <= (state_next_s == ST_ENABLE) && !peak_s;
            busy_r       <= (state_next_s != ST_IDLE);
`ifdef ACCESS_LOCKOUT_EN
            fail_count_r <= fail_next_s;
            locked_r     <= (state_next_s == ST_LOCKOUT);
`endif
        end
    end

    assign bus.P_register_enable = p_en_r;
    assign bus.Q_register_enable = q_en_r;
    assign bus.busy              = busy_r;
`ifdef ACCESS_LOCKOUT_EN
    assign bus.locked            = locked_r;
    assign bus.fail_count        = fail_count_r;
`else
    assign bus.locked            = 1'b0;
    assign bus.fail_count        = '0;
`endif

endmodule

// File: tb/tb_parking_access_controller.sv
// Scoreboard bench for parking_access_controller. Stimulus pushes the
// expected enable (P/Q value and cycle) into a queue before the second
// confirm; a negedge monitor pops and compares whenever an enable is seen.
// Status outputs are compared directly after the relevant edges.
module tb_parking_access_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   passed = 0;

    typedef struct {
        logic p;
        logic q;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    parking_access_controller_if #(.TOKEN_W(3), .TIME_W(8), .FAIL_W(2)) bus ();

    parking_access_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle counter used to time-stamp expected enables.
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every enable seen must match the oldest expected entry.
    always @(negedge clock) begin
        if (bus.P_register_enable || bus.Q_register_enable) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_enable: got P=%0b Q=%0b at cycle %0d, required no enable",
                         bus.P_register_enable, bus.Q_register_enable, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.P_register_enable == mon_e.p && bus.Q_register_enable == mon_e.q &&
                    cyc == mon_e.cyc) begin
                    passed = passed + 1;
                end else begin
                    $display("FAIL enable: got P=%0b Q=%0b cycle %0d, required P=%0b Q=%0b cycle %0d",
                             bus.P_register_enable, bus.Q_register_enable, cyc,
                             mon_e.p, mon_e.q, mon_e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act === req) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expect an enable in the cycle after the confirm about to be driven.
    task automatic expect_en(input logic p, input logic q);
        exp_t e;
        e.p = p;
        e.q = q;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic confirm_pulse(input logic [2:0] tok);
        bus.user_token = tok;
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
    endtask

    initial begin
        bus.request      = 1'b0;
        bus.confirm      = 1'b0;
        bus.system_token = 3'b101;
        bus.user_token   = 3'b000;
        bus.time_data    = 8'hF5;
        reset            = 1'b1;
        step();
        step();
        chk("reset_busy",   {31'd0, bus.busy}, 32'd0);
        chk("reset_locked", {31'd0, bus.locked}, 32'd0);
        chk("reset_fail",   {30'd0, bus.fail_count}, 32'd0);
        chk("reset_P",      {31'd0, bus.P_register_enable}, 32'd0);
        reset = 1'b0;
        step();

        // 1: peak time -> P pulse
        bus.time_data = 8'hF5;
        bus.request = 1'b1;
        step();
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        confirm_pulse(3'b101);
        expect_en(1'b1, 1'b0);
        confirm_pulse(3'b101);
        step();
        chk("t1_release_busy", {31'd0, bus.busy}, 32'd1);

        // 2: off-peak -> Q pulse, extra confirm ignored, drop request
        bus.request = 1'b0;
        step();
        chk("t2_idle_busy", {31'd0, bus.busy}, 32'd0);
        bus.time_data = 8'hE0;
        bus.request = 1'b1;
        step();
        confirm_pulse(3'b101);
        expect_en(1'b0, 1'b1);
        confirm_pulse(3'b101);
        step();
        confirm_pulse(3'b101);
        step();
        chk("t2_still_busy", {31'd0, bus.busy}, 32'd1);
        bus.request = 1'b0;
        step();
        chk("t2_drop_busy", {31'd0, bus.busy}, 32'd0);

`ifdef ACCESS_LOCKOUT_EN
        // 3: three mismatches -> lockout
        bus.request = 1'b1;
        step();
        confirm_pulse(3'b010);
        chk("t3_fail1", {30'd0, bus.fail_count}, 32'd1);
        chk("t3_lock1", {31'd0, bus.locked}, 32'd0);
        confirm_pulse(3'b010);
        chk("t3_fail2", {30'd0, bus.fail_count}, 32'd2);
        confirm_pulse(3'b010);
        chk("t3_locked", {31'd0, bus.locked}, 32'd1);
        chk("t3_fail3", {30'd0, bus.fail_count}, 32'd3);
        confirm_pulse(3'b101);
        confirm_pulse(3'b101);
        bus.request = 1'b0;
        step();
        chk("t3_sticky", {31'd0, bus.locked}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t3_rst_locked", {31'd0, bus.locked}, 32'd0);
        chk("t3_rst_fail", {30'd0, bus.fail_count}, 32'd0);

        // 4: two mismatches then match clears count and enables
        bus.request = 1'b1;
        step();
        confirm_pulse(3'b010);
        confirm_pulse(3'b011);
        chk("t4_fail2", {30'd0, bus.fail_count}, 32'd2);
        confirm_pulse(3'b101);
        chk("t4_fail0", {30'd0, bus.fail_count}, 32'd0);
        expect_en(1'b0, 1'b1);
        confirm_pulse(3'b101);
        step();
        bus.request = 1'b0;
        step();
`else
        // 3 (no lockout): mismatch aborts the session, no enable
        bus.request = 1'b1;
        step();
        confirm_pulse(3'b010);
        chk("t3_abort_busy", {31'd0, bus.busy}, 32'd1);
        chk("t3_locked0", {31'd0, bus.locked}, 32'd0);
        chk("t3_fail0", {30'd0, bus.fail_count}, 32'd0);
        confirm_pulse(3'b101);
        confirm_pulse(3'b101);
        bus.request = 1'b0;
        step();
        chk("t3_idle", {31'd0, bus.busy}, 32'd0);
`endif

        // 5a: waiting below the timeout still allows the session
        bus.time_data = 8'hF0;
        bus.request = 1'b1;
        step();
        repeat (200) step();
        confirm_pulse(3'b101);
        expect_en(1'b1, 1'b0);
        confirm_pulse(3'b101);
        step();
        bus.request = 1'b0;
        step();

        // 5b: idle past the timeout -> RELEASE, confirms ignored
        bus.request = 1'b1;
        step();
        repeat (300) step();
        confirm_pulse(3'b101);
        confirm_pulse(3'b101);
        step();
        chk("t5_release_busy", {31'd0, bus.busy}, 32'd1);
        bus.request = 1'b0;
        step();

        // 6a: reset with confirm in VERIFIED -> IDLE, no enable
        bus.request = 1'b1;
        step();
        confirm_pulse(3'b101);
        bus.user_token = 3'b101;
        bus.confirm = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.confirm = 1'b0;
        chk("t6_reset_busy", {31'd0, bus.busy}, 32'd0);
        step();
        step();
        // 6b: request dropped in VERIFIED -> IDLE, no enable
        confirm_pulse(3'b101);
        bus.request = 1'b0;
        step();
        chk("t6_drop_busy", {31'd0, bus.busy}, 32'd0);
        confirm_pulse(3'b101);
        repeat (3) step();

        chk("pending_enables", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
